// File: rtl/vga_nios_button_pio.sv
// ---------------------------------------------------------------------------
// vga_nios_button_pio
//
// Avalon-MM input PIO for the push-buttons and switches on the VGA Nios
// system. Each input bit is synchronised, optionally debounced and
// edge-detected. Detected edges are latched in a write-1-to-clear
// edge_capture register, which drives a maskable level interrupt.
//
// Register map (word addresses):
//   0 : data         read-only, debounced input levels
//   1 : reserved     reads 0, writes ignored
//   2 : irq_mask     read/write, WIDTH bits
//   3 : edge_capture read; a write clears every bit where writedata=1
//
// Ports:
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   address    word address (2 bits)
//   chipselect slave select
//   write_n    active-low write strobe
//   writedata  32-bit write data
//   in_port    raw asynchronous button/switch inputs (WIDTH bits)
//   irq        level interrupt, |(edge_capture & irq_mask)
//   readdata   registered read data, one-cycle latency
//
// Parameters:
//   WIDTH           number of input bits, 1..32
//   DEBOUNCE_CYCLES cycles an input must hold its new value before it is
//                   accepted, >= 2 (only used with BUTTON_PIO_DEBOUNCE_EN)
//   EDGE_MODE       0 = rising, 1 = falling, 2 = any edge
//
// Build option:
//   BUTTON_PIO_DEBOUNCE_EN  defined: per-bit debounce counters are built.
//                           undefined: stable follows the synchroniser
//                           output every cycle (3-edge latency).
// ---------------------------------------------------------------------------
module vga_nios_button_pio #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int EDGE_MODE       = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq,
  output logic [31:0]      readdata
);

  typedef enum logic [1:0] {
    ADDR_DATA     = 2'd0,
    ADDR_RESERVED = 2'd1,
    ADDR_MASK     = 2'd2,
    ADDR_CAPTURE  = 2'd3
  } reg_addr_t;

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] accept;
  logic [WIDTH-1:0] irq_mask;
  logic [WIDTH-1:0] edge_capture;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] capture_clr;
  logic [31:0]      read_mux;
  logic             wr_en;
  logic             unused_writedata;

  // Upper write-data bits are ignored when WIDTH < 32.
  assign unused_writedata = ^writedata;

  // -------------------------------------------------------------------------
  // Two-flop synchroniser per bit.
  // -------------------------------------------------------------------------
  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= in_port;
      sync2 <= sync1;
    end
  end

`ifdef BUTTON_PIO_DEBOUNCE_EN
  // -------------------------------------------------------------------------
  // Per-bit debounce: sync2 must differ from stable for DEBOUNCE_CYCLES
  // consecutive cycles before it is accepted. A return to the stable value
  // restarts the count.
  // -------------------------------------------------------------------------
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] db_cnt [WIDTH];

  always_comb begin
    accept = '0;
    for (int i = 0; i < WIDTH; i++) begin
      accept[i] = (sync2[i] != stable[i]) && (db_cnt[i] == CNT_MAX);
    end
  end

  // NOTE: the counter array is small and its value matters after reset, so
  // every element is reset explicitly rather than left as an unreset memory.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        db_cnt[i] <= '0;
      end
      stable <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (accept[i]) begin
          stable[i] <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  // Without debounce every synchronised change is accepted on the next edge.
  assign accept = '1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable <= '0;
    end else begin
      stable <= sync2;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Edge detection, aligned with the edge on which stable updates.
  // -------------------------------------------------------------------------
  // NOTE: every combinational output gets a default before the case so no
  // path leaves it unassigned (which would infer a latch).
  always_comb begin
    edge_det = '0;
    case (EDGE_MODE)
      0:       edge_det = ~stable &  sync2 & accept;
      1:       edge_det =  stable & ~sync2 & accept;
      default: edge_det = (stable ^ sync2) & accept;
    endcase
  end

  // -------------------------------------------------------------------------
  // Register writes.
  // -------------------------------------------------------------------------
  assign wr_en       = chipselect & ~write_n;
  assign capture_clr = (wr_en && (address == ADDR_CAPTURE)) ?
                       writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_mask     <= '0;
      edge_capture <= '0;
    end else begin
      if (wr_en && (address == ADDR_MASK)) begin
        irq_mask <= writedata[WIDTH-1:0];
      end
      // Set is ORed in after the clear so a simultaneous edge is never lost.
      edge_capture <= (edge_capture & ~capture_clr) | edge_det;
    end
  end

  // -------------------------------------------------------------------------
  // Read path: registered every cycle, chipselect does not gate it.
  // -------------------------------------------------------------------------
  always_comb begin
    read_mux = '0;
    case (reg_addr_t'(address))
      ADDR_DATA:     read_mux[WIDTH-1:0] = stable;
      ADDR_MASK:     read_mux[WIDTH-1:0] = irq_mask;
      ADDR_CAPTURE:  read_mux[WIDTH-1:0] = edge_capture;
      default:       read_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata <= '0;
    end else begin
      readdata <= read_mux;
    end
  end

  assign irq = |(edge_capture & irq_mask);

endmodule

// File: tb/tb_vga_nios_button_pio.sv
// ---------------------------------------------------------------------------
// Testbench for vga_nios_button_pio. Two instances share the Avalon bus:
// dut_a uses rising-edge capture, dut_b any-edge capture. Expected input
// latency follows BUTTON_PIO_DEBOUNCE_EN (2+DEBOUNCE_CYCLES edges when
// defined, 3 edges otherwise).
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vga_nios_button_pio;

  localparam int WIDTH = 4;
  localparam int DEB   = 4;
`ifdef BUTTON_PIO_DEBOUNCE_EN
  localparam int LAT   = 2 + DEB;
`else
  localparam int LAT   = 3;
`endif

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [3:0]  in_a;
  logic [3:0]  in_b;
  logic        irq_a;
  logic        irq_b;
  logic [31:0] readdata_a;
  logic [31:0] readdata_b;

  int errors = 0;
  int checks = 0;

  vga_nios_button_pio #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(0)) dut_a (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_a),
    .irq        (irq_a),
    .readdata   (readdata_a)
  );

  vga_nios_button_pio #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DEB), .EDGE_MODE(2)) dut_b (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .in_port    (in_b),
    .irq        (irq_b),
    .readdata   (readdata_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] rd_a,
                          output logic [31:0] rd_b);
    @(negedge clk);
    address    = a;
    chipselect = 1'b1;
    write_n    = 1'b1;
    @(negedge clk);
    rd_a       = readdata_a;
    rd_b       = readdata_b;
    chipselect = 1'b0;
  endtask

  logic [31:0] ra, rb;

  initial begin
    reset_n    = 1'b0;
    address    = '0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    in_a       = '0;
    in_b       = '0;
    repeat (3) @(negedge clk);
    check("rst_readdata", readdata_a, 32'h0);
    reset_n = 1'b1;

    // Reset state through the bus.
    bus_read(2'd0, ra, rb); check("rst_data", ra, 32'h0);
    bus_read(2'd2, ra, rb); check("rst_mask", ra, 32'h0);
    bus_read(2'd3, ra, rb); check("rst_capture", ra, 32'h0);
    check("rst_irq", {31'b0, irq_a}, 32'h0);

    // Mask write and readback; reserved register ignores writes.
    bus_write(2'd2, 32'h0000_0005);
    bus_write(2'd1, 32'hFFFF_FFFF);
    bus_read(2'd2, ra, rb); check("mask_rb", ra, 32'h5);
    bus_read(2'd1, ra, rb); check("reserved", ra, 32'h0);

    // Rising edge on bit0: stable and capture update on edge LAT.
    @(negedge clk);
    in_a[0]    = 1'b1;
    address    = 2'd0;
    chipselect = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      if (k == LAT - 1) check("rise_irq_early", {31'b0, irq_a}, 32'h0);
      if (k == LAT)     check("rise_irq", {31'b0, irq_a}, 32'h1);
      if (k == LAT)     check("rise_data_early", readdata_a, 32'h0);
      if (k == LAT + 1) check("rise_data", readdata_a, 32'h1);
    end
    chipselect = 1'b0;
    bus_read(2'd3, ra, rb); check("rise_capture", ra, 32'h1);

`ifdef BUTTON_PIO_DEBOUNCE_EN
    // 3-cycle pulse on bit2 is shorter than the debounce window.
    @(negedge clk);
    in_a[2] = 1'b1;
    repeat (3) @(negedge clk);
    in_a[2] = 1'b0;
    repeat (8) @(negedge clk);
    bus_read(2'd0, ra, rb); check("glitch_data", ra, 32'h1);
    bus_read(2'd3, ra, rb); check("glitch_capture", ra, 32'h1);
    check("glitch_irq", {31'b0, irq_a}, 32'h1);
`endif

    // Write-1-to-clear.
    bus_write(2'd3, 32'h1);
    check("clr_irq", {31'b0, irq_a}, 32'h0);
    bus_read(2'd3, ra, rb); check("clr_capture", ra, 32'h0);

    // Falling edge is ignored in rising mode.
    @(negedge clk);
    in_a[0] = 1'b0;
    repeat (LAT + 3) @(negedge clk);
    bus_read(2'd3, ra, rb); check("fall_ignored", ra, 32'h0);
    bus_read(2'd0, ra, rb); check("fall_data", ra, 32'h0);

    // Capture-set and write-1-clear on bit1 on the same edge: set wins.
    @(negedge clk);
    in_a[1] = 1'b1;
    repeat (LAT - 1) @(negedge clk);
    address    = 2'd3;
    writedata  = 32'h2;
    chipselect = 1'b1;
    write_n    = 1'b0;
    @(negedge clk);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = '0;
    bus_read(2'd3, ra, rb); check("collide_capture", ra, 32'h2);
    check("collide_irq", {31'b0, irq_a}, 32'h0);

    // Any-edge instance: rising edge on bit3.
    @(negedge clk);
    in_b[3]    = 1'b1;
    address    = 2'd3;
    chipselect = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      if (k == LAT)     check("any_rise_early", readdata_b, 32'h0);
      if (k == LAT + 1) check("any_rise", readdata_b, 32'h8);
    end
    chipselect = 1'b0;
    bus_write(2'd3, 32'h8);
    bus_read(2'd3, ra, rb); check("any_clr", rb, 32'h0);

    // Any-edge instance: falling edge on bit3.
    @(negedge clk);
    in_b[3]    = 1'b0;
    address    = 2'd3;
    chipselect = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(posedge clk); #1;
      if (k == LAT)     check("any_fall_early", readdata_b, 32'h0);
      if (k == LAT + 1) check("any_fall", readdata_b, 32'h8);
    end
    chipselect = 1'b0;
    check("any_irq_masked", {31'b0, irq_b}, 32'h0);
    bus_write(2'd2, 32'h8);
    check("any_irq", {31'b0, irq_b}, 32'h1);

    // Mid-operation reset clears state immediately.
    @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_irq", {31'b0, irq_b}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    in_a    = '0;
    bus_read(2'd2, ra, rb);
    check("midrst_mask_a", ra, 32'h0);
    check("midrst_mask_b", rb, 32'h0);
    bus_read(2'd3, ra, rb);
    check("midrst_cap_a", ra, 32'h0);
    check("midrst_cap_b", rb, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
